// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequences ROM fetches into an instruction register and issues them to decode via valid/ready
module fetch_sequencer #(
  parameter int Awidth = 4,
  parameter int Dwidth = 16
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              halt,
  output logic [Awidth-1:0] pc,
  output logic              oeb,
  input  logic [Dwidth-1:0] inst,
  output logic [Dwidth-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              branch_en,
  input  logic [Awidth-1:0] branch_target,
  output logic [7:0]        issue_cnt,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, HALTED} state_t;
  state_t state;
  assign busy = (state == FETCH) || (state == WAIT) || (state == ISSUE);
  // fetch loop: one-cycle oeb strobe, one settle cycle, then hold ir until decode takes it
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      state     <= IDLE;
      pc        <= '0;
      oeb       <= 1'b0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      issue_cnt <= '0;
    end else begin
      case (state)
        IDLE, HALTED:
          if (start) begin
            state <= FETCH;
            oeb   <= 1'b1;
          end
        FETCH: begin
          state <= WAIT;
          oeb   <= 1'b0;
        end
        WAIT: begin
          state    <= ISSUE;
          ir       <= inst;
          ir_valid <= 1'b1;
        end
        ISSUE:
          if (ir_valid && ir_ready) begin
            ir_valid  <= 1'b0;
            issue_cnt <= issue_cnt + 8'd1;
            pc        <= branch_en ? branch_target : pc + 1'b1;
            state     <= halt ? HALTED : FETCH;
            oeb       <= !halt;
          end
        default: begin
          state <= IDLE;
          oeb   <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks of fetch_sequencer against a timeline model
module tb_fetch_sequencer;
  localparam int AW = 4;
  localparam int DW = 16;
  logic clk = 1'b0, rstb = 1'b0, start = 1'b0, halt = 1'b0, ir_ready = 1'b0, branch_en = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic [AW-1:0] pc;
  logic oeb, ir_valid, busy;
  logic [DW-1:0] inst, ir;
  logic [7:0] issue_cnt;
  logic [DW-1:0] mem [16];
  int vectors = 0;
  int miscompares = 0;

  fetch_sequencer #(.Awidth(AW), .Dwidth(DW)) dut (
    .clk(clk), .rstb(rstb), .start(start), .halt(halt), .pc(pc), .oeb(oeb),
    .inst(inst), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .branch_en(branch_en), .branch_target(branch_target),
    .issue_cnt(issue_cnt), .busy(busy)
  );

  always #5 clk = ~clk;
  initial for (int k = 0; k < 16; k++) mem[k] = 16'h1000 + 16'(k);
  assign inst = mem[pc];

  // model: a launched fetch strobes in its first cycle, presents mem[pc] from its third, then waits for acceptance
  logic m_run = 1'b0, m_valid = 1'b0;
  int m_age = 0;
  logic [AW-1:0] m_pc = '0;
  logic [DW-1:0] m_ir = '0;
  logic [7:0] m_cnt = '0;
  always @(posedge clk or negedge rstb)
    if (!rstb) begin
      m_run = 1'b0; m_age = 0; m_valid = 1'b0; m_pc = '0; m_ir = '0; m_cnt = '0;
    end else if (!m_run) begin
      if (start) begin m_run = 1'b1; m_age = 0; end
    end else if (m_age < 2) begin
      m_age++;
      if (m_age == 2) begin m_ir = mem[m_pc]; m_valid = 1'b1; end
    end else if (ir_ready) begin
      m_valid = 1'b0;
      m_cnt = m_cnt + 8'd1;
      m_pc = branch_en ? branch_target : m_pc + 4'd1;
      if (halt) m_run = 1'b0; else m_age = 0;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // every cycle: DUT outputs against the model
  always @(negedge clk) begin
    chk("pc", 32'(pc), 32'(m_pc));
    chk("oeb", 32'(oeb), 32'(m_run && m_age == 0));
    chk("ir", 32'(ir), 32'(m_ir));
    chk("ir_valid", 32'(ir_valid), 32'(m_valid));
    chk("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_run));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_issue();
    for (int i = 0; i < 10 && !ir_valid; i++) tick();
    chk("issue_reached", 32'(ir_valid), 1);
  endtask

  initial begin
    ir_ready = 1'b1;
    repeat (2) tick();
    rstb = 1'b1;
    tick();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_oeb", 32'(oeb), 0);
    chk("rst_ir", 32'(ir), 0);
    chk("rst_valid", 32'(ir_valid), 0);
    chk("rst_cnt", 32'(issue_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("e0_oeb", 32'(oeb), 1);
    chk("e0_pc", 32'(pc), 0);
    tick();
    chk("e1_oeb", 32'(oeb), 0);
    tick();
    chk("e2_valid", 32'(ir_valid), 1);
    chk("e2_ir", 32'(ir), 32'h1000);
    tick();
    chk("hs_oeb", 32'(oeb), 1);
    chk("hs_pc", 32'(pc), 1);
    chk("hs_cnt", 32'(issue_cnt), 1);
    tick(); tick();
    chk("ir1", 32'(ir), 32'h1001);
    tick(); tick();
    branch_en = 1'b1; branch_target = 4'hA;
    tick();
    chk("wait_branch_pc", 32'(pc), 2);
    chk("ir2", 32'(ir), 32'h1002);
    tick(); branch_en = 1'b0;
    chk("br_pc", 32'(pc), 10);
    chk("br_oeb", 32'(oeb), 1);
    wait_issue();
    chk("ir_a", 32'(ir), 32'h100A);
    branch_en = 1'b1; branch_target = 4'h3; tick(); branch_en = 1'b0; ir_ready = 1'b0;
    wait_issue();
    chk("stall_ir0", 32'(ir), 32'h1003);
    repeat (5) begin
      tick();
      chk("stall_valid", 32'(ir_valid), 1);
      chk("stall_ir", 32'(ir), 32'h1003);
      chk("stall_oeb", 32'(oeb), 0);
      chk("stall_pc", 32'(pc), 3);
    end
    ir_ready = 1'b1; tick();
    chk("rel_pc", 32'(pc), 4);
    chk("rel_oeb", 32'(oeb), 1);
    wait_issue();
    branch_en = 1'b1; branch_target = 4'hF; tick(); branch_en = 1'b0;
    wait_issue();
    chk("pc15", 32'(pc), 15);
    chk("ir15", 32'(ir), 32'h100F);
    tick();
    chk("wrap_pc", 32'(pc), 0);
    chk("wrap_oeb", 32'(oeb), 1);
    wait_issue();
    chk("wrap_ir", 32'(ir), 32'h1000);
    branch_en = 1'b1; branch_target = 4'h5; tick(); branch_en = 1'b0;
    wait_issue();
    chk("pc5", 32'(pc), 5);
    halt = 1'b1; branch_en = 1'b1; branch_target = 4'h1; tick(); halt = 1'b0; branch_en = 1'b0;
    chk("hb_pc", 32'(pc), 1);
    chk("hb_valid", 32'(ir_valid), 0);
    chk("hb_busy", 32'(busy), 0);
    chk("hb_oeb", 32'(oeb), 0);
    repeat (3) begin
      tick();
      chk("halt_oeb", 32'(oeb), 0);
      chk("halt_pc", 32'(pc), 1);
    end
    start = 1'b1; tick(); start = 1'b0;
    chk("resume_oeb", 32'(oeb), 1);
    chk("resume_pc", 32'(pc), 1);
    #1 rstb = 1'b0;
    #1;
    chk("ar_oeb", 32'(oeb), 0);
    chk("ar_pc", 32'(pc), 0);
    chk("ar_valid", 32'(ir_valid), 0);
    chk("ar_cnt", 32'(issue_cnt), 0);
    chk("ar_busy", 32'(busy), 0);
    tick(); rstb = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_busy", 32'(busy), 0);
      chk("idle_oeb", 32'(oeb), 0);
    end
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 255; i++) begin
      wait_issue();
      tick();
    end
    wait_issue();
    chk("cnt255", 32'(issue_cnt), 255);
    halt = 1'b1; tick(); halt = 1'b0;
    chk("cnt_wrap", 32'(issue_cnt), 0);
    chk("cnt_busy", 32'(busy), 0);
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      halt = ($urandom_range(0, 7) == 0);
      ir_ready = ($urandom_range(0, 1) == 0);
      branch_en = ($urandom_range(0, 3) == 0);
      branch_target = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        rstb = 1'b0;
        #1 rstb = 1'b1;
      end
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
